i2s_receiver: RTL and testbench

I2S bus master receiver. Generates the bit clock (bclk_o) and word-select clock (lrclk_o) from the system clock, and deserialises 24-bit two's-complement samples from audio_data_i in standard Philips I2S format (MSB one bclk after each lrclk edge). Each completed channel sample is presented on audio_data_o with a one-cycle new_sample_o strobe. Sits between an external I2S ADC/codec and the audio processing pipeline.

---
 rtl/i2s_pkg.sv | 12 +
 rtl/i2s_clk_gen.sv | 65 ++++++
 rtl/i2s_receiver.sv | 112 +++++++++++
 tb/tb_i2s_receiver.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// Shared I2S receiver types and default geometry.
package i2s_pkg;
  localparam int I2S_DATA_WIDTH = 24;
  localparam int I2S_SLOT_BITS  = 24;

  typedef enum logic {
    CH_LEFT  = 1'b0,
    CH_RIGHT = 1'b1
  } channel_e;

  typedef logic [I2S_DATA_WIDTH-1:0] sample_t;
endpackage

// File: rtl/i2s_clk_gen.sv
// I2S bus clock generator: bclk divider, slot bit counter, lrclk, and the
// bclk edge strobes that line up with the cycle each registered edge appears.
module i2s_clk_gen #(
  parameter int CLK_DIV   = 8,
  parameter int SLOT_BITS = 24,
  localparam int BW       = $clog2(SLOT_BITS)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_enable,
  output logic          o_bclk,
  output logic          o_lrclk,
  output logic          o_bclk_rise,
  output logic          o_bclk_fall,
  output logic          o_slot_start,
  output logic [BW-1:0] o_bit_cnt
);
  localparam int DIVW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIVW-1:0] DIV_MAX  = DIVW'(CLK_DIV - 1);
  localparam logic [BW-1:0]   BIT_LAST = BW'(SLOT_BITS - 1);

  logic [DIVW-1:0] r_div;
  logic [BW-1:0]   r_bit;
  logic            r_bclk;
  logic            r_lrclk;
  logic            w_wrap;

  // Strobes are asserted in the cycle whose clock edge moves bclk.
  assign w_wrap       = i_enable && (r_div == DIV_MAX);
  assign o_bclk_rise  = w_wrap && !r_bclk;
  assign o_bclk_fall  = w_wrap && r_bclk;
  assign o_slot_start = o_bclk_fall && (r_bit == BIT_LAST);
  assign o_bclk       = r_bclk;
  assign o_lrclk      = r_lrclk;
  assign o_bit_cnt    = r_bit;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_div   <= '0;
      r_bit   <= '0;
      r_bclk  <= 1'b0;
      r_lrclk <= 1'b0;
    end else if (!i_enable) begin
      r_div   <= '0;
      r_bit   <= '0;
      r_bclk  <= 1'b0;
      r_lrclk <= 1'b0;
    end else begin
      if (w_wrap) begin
        r_div  <= '0;
        r_bclk <= ~r_bclk;
      end else begin
        r_div <= r_div + 1'b1;
      end
      if (o_bclk_fall) begin
        if (o_slot_start) begin
          r_bit   <= '0;
          r_lrclk <= ~r_lrclk;
        end else begin
          r_bit <= r_bit + 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/i2s_receiver.sv
// I2S master receiver: drives bclk/lrclk and deserialises Philips-format samples.
// Optional channel tag output enabled by I2S_RECEIVER_CHANNEL_TAG_EN.
module i2s_receiver
  import i2s_pkg::*;
#(
  parameter int CLK_DIV    = 8,
  parameter int DATA_WIDTH = I2S_DATA_WIDTH,
  parameter int SLOT_BITS  = I2S_SLOT_BITS
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  enable_i,
  input  logic                  audio_data_i,
  output logic [DATA_WIDTH-1:0] audio_data_o,
  output logic                  bclk_o,
  output logic                  lrclk_o,
  output logic                  new_sample_o
`ifdef I2S_RECEIVER_CHANNEL_TAG_EN
  ,
  output logic                  channel_o
`endif
);
  localparam int BW = $clog2(SLOT_BITS);
  localparam logic [BW-1:0] LAST_DATA_BIT = BW'(DATA_WIDTH - 1);

  logic                  w_bclk_rise;
  logic                  w_bclk_fall;
  logic                  w_slot_start;
  logic [BW-1:0]         w_bit_cnt;
  logic [DATA_WIDTH-1:0] w_shift_next;

  logic [DATA_WIDTH-2:0] r_shift;
  logic                  r_first;
  logic                  r_k0;
  logic                  r_done_vld;
  logic [DATA_WIDTH-1:0] r_done_word;
`ifdef I2S_RECEIVER_CHANNEL_TAG_EN
  channel_e              r_done_ch;
`endif

  i2s_clk_gen #(
    .CLK_DIV   (CLK_DIV),
    .SLOT_BITS (SLOT_BITS)
  ) u_clk_gen (
    .i_clk        (clk_i),
    .i_rst        (rst_i),
    .i_enable     (enable_i),
    .o_bclk       (bclk_o),
    .o_lrclk      (lrclk_o),
    .o_bclk_rise  (w_bclk_rise),
    .o_bclk_fall  (w_bclk_fall),
    .o_slot_start (w_slot_start),
    .o_bit_cnt    (w_bit_cnt)
  );

  assign w_shift_next = {r_shift, audio_data_i};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_shift      <= '0;
      r_first      <= 1'b1;
      r_k0         <= 1'b1;
      r_done_vld   <= 1'b0;
      r_done_word  <= '0;
      audio_data_o <= '0;
      new_sample_o <= 1'b0;
`ifdef I2S_RECEIVER_CHANNEL_TAG_EN
      r_done_ch    <= CH_LEFT;
      channel_o    <= 1'b0;
`endif
    end else if (!enable_i) begin
      r_shift      <= '0;
      r_first      <= 1'b1;
      r_k0         <= 1'b1;
      r_done_vld   <= 1'b0;
      r_done_word  <= '0;
      new_sample_o <= 1'b0;
`ifdef I2S_RECEIVER_CHANNEL_TAG_EN
      r_done_ch    <= CH_LEFT;
      channel_o    <= 1'b0;
`endif
    end else begin
      // r_k0 marks that the next bclk rise is the one-bit-delayed LSB slot.
      if (w_slot_start) begin
        r_k0 <= 1'b1;
      end else if (w_bclk_fall) begin
        r_k0 <= 1'b0;
      end
      r_done_vld <= 1'b0;
      if (w_bclk_rise) begin
        if (r_k0) begin
          r_first     <= 1'b0;
          r_done_vld  <= ~r_first;
          r_done_word <= w_shift_next;
          r_shift     <= '0;
`ifdef I2S_RECEIVER_CHANNEL_TAG_EN
          r_done_ch   <= channel_e'(~lrclk_o);
`endif
        end else if (w_bit_cnt <= LAST_DATA_BIT) begin
          r_shift <= w_shift_next[DATA_WIDTH-2:0];
        end
      end
      new_sample_o <= r_done_vld;
      if (r_done_vld) begin
        audio_data_o <= r_done_word;
`ifdef I2S_RECEIVER_CHANNEL_TAG_EN
        channel_o    <= r_done_ch;
`endif
      end
    end
  end
endmodule

// File: tb/tb_i2s_receiver.sv
// Bench for i2s_receiver: wire-level codec model feeding per-slot words, scoreboard of expected samples.
`timescale 1ns/1ps
module tb_i2s_receiver;
  localparam int CLK_DIV = 8;
  localparam int DW      = 24;
  localparam int SB      = 24;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          enable_i;
  logic          audio_data_i;
  logic [DW-1:0] audio_data_o;
  logic          bclk_o;
  logic          lrclk_o;
  logic          new_sample_o;
`ifdef I2S_RECEIVER_CHANNEL_TAG_EN
  logic          channel_o;
`endif

  i2s_receiver #(
    .CLK_DIV    (CLK_DIV),
    .DATA_WIDTH (DW),
    .SLOT_BITS  (SB)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .enable_i     (enable_i),
    .audio_data_i (audio_data_i),
    .audio_data_o (audio_data_o),
    .bclk_o       (bclk_o),
    .lrclk_o      (lrclk_o),
    .new_sample_o (new_sample_o)
`ifdef I2S_RECEIVER_CHANNEL_TAG_EN
    ,
    .channel_o    (channel_o)
`endif
  );

  initial forever #12.5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] tx_q[$];
  logic [DW-1:0] exp_q[$];
  logic          exp_ch_q[$];
  logic [DW-1:0] cur_word;
  logic [DW-1:0] held;
  int            p;
  int            cyc = 0;
  int            en_cyc, last_rise, last_lr, rises, lr_edges, pulses;
  int            ns_seen;
  logic          prev_b, prev_l, prev_ns;

  task automatic chk(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [DW-1:0] next_word();
    if (tx_q.size() > 0) return tx_q.pop_front();
    return DW'($urandom);
  endfunction

  task automatic codec_start();
    p         = 0;
    prev_b    = 1'b0;
    prev_l    = 1'b0;
    prev_ns   = 1'b0;
    cur_word  = next_word();
    en_cyc    = cyc;
    last_rise = -1;
    last_lr   = -1;
    rises     = 0;
    lr_edges  = 0;
  endtask

  // One clock: observe the bus, play the codec on bclk falls, score pulses.
  task automatic step();
    logic b, l, ns;
    logic [DW-1:0] w;
    logic ch;
    @(posedge clk_i);
    #1;
    cyc++;
    b  = bclk_o;
    l  = lrclk_o;
    ns = new_sample_o;
    if (enable_i && !rst_i) begin
      if (b && !prev_b) begin
        if (rises == 0) chk("first_bclk_rise", cyc - en_cyc, CLK_DIV);
        else            chk("bclk_period", cyc - last_rise, 2 * CLK_DIV);
        rises++;
        last_rise = cyc;
      end
      if (l != prev_l) chk("lrclk_edge_with_bclk_fall", 32'({prev_b, b}), 32'(2'b10));
      if (!b && prev_b) begin
        if (l != prev_l) begin
          if (last_lr >= 0) chk("lrclk_half_period", cyc - last_lr, 2 * CLK_DIV * SB);
          last_lr = cyc;
          lr_edges++;
          audio_data_i = cur_word[0];
          exp_q.push_back(cur_word);
          exp_ch_q.push_back(prev_l);
          cur_word = next_word();
          p = 0;
        end else begin
          p++;
          if (p < DW) audio_data_i = cur_word[DW-p];
          else        audio_data_i = 1'($urandom);
        end
      end
      if (ns) begin
        chk("pulse_width", 32'(prev_ns), 0);
        chk("pulse_latency", cyc - last_lr, CLK_DIV + 1);
        chk("pulse_has_word", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          w  = exp_q.pop_front();
          ch = exp_ch_q.pop_front();
          chk("sample_data", 32'(audio_data_o), 32'(w));
`ifdef I2S_RECEIVER_CHANNEL_TAG_EN
          chk("channel_tag", 32'(channel_o), 32'(ch));
`else
          if (ch === 1'bx) chk("channel_model", 32'(ch), 0);
`endif
        end
        pulses++;
      end
    end
    prev_b  = b;
    prev_l  = l;
    prev_ns = ns;
  endtask

  task automatic run_pulses(input int n, input int budget);
    int target;
    target = pulses + n;
    for (int i = 0; i < budget && pulses < target; i++) step();
    chk("pulse_count", pulses, target);
  endtask

  task automatic run_until_bit(input int k, input int budget);
    for (int i = 0; i < budget && !(lr_edges >= 1 && p == k); i++) step();
    chk("reached_bit", p, k);
  endtask

  initial begin
    pulses       = 0;
    rst_i        = 1'b1;
    enable_i     = 1'b0;
    audio_data_i = 1'b0;
    prev_b       = 1'b0;
    prev_l       = 1'b0;
    prev_ns      = 1'b0;
    repeat (3) step();
    chk("rst_bclk", 32'(bclk_o), 0);
    chk("rst_lrclk", 32'(lrclk_o), 0);
    chk("rst_data", 32'(audio_data_o), 0);
    chk("rst_new_sample", 32'(new_sample_o), 0);

    rst_i = 1'b0;
    repeat (5) step();
    chk("idle_bclk", 32'(bclk_o), 0);
    chk("idle_lrclk", 32'(lrclk_o), 0);
    chk("idle_new_sample", 32'(new_sample_o), 0);

    // Directed words, then random traffic.
    tx_q = '{24'h20F3FF, 24'h20F3FB, 24'h20F3F7};
    enable_i = 1'b1;
    codec_start();
    run_pulses(3, 3000);
    run_pulses(6, 5000);

    // Drop enable mid-slot.
    run_until_bit(10, 1000);
    held     = audio_data_o;
    enable_i = 1'b0;
    ns_seen  = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (new_sample_o) ns_seen++;
    end
    chk("dis_no_pulse", ns_seen, 0);
    chk("dis_bclk", 32'(bclk_o), 0);
    chk("dis_lrclk", 32'(lrclk_o), 0);
    chk("dis_data_hold", 32'(audio_data_o), 32'(held));
    chk("dis_no_pending", exp_q.size(), 0);
    exp_q.delete();
    exp_ch_q.delete();

    // Re-enable: left word then right word.
    tx_q = '{24'h000001, 24'h800000};
    enable_i = 1'b1;
    codec_start();
    run_pulses(4, 4000);

    // Reset mid-slot: immediate, no pulse for the partial word.
    run_until_bit(5, 1000);
    rst_i = 1'b1;
    #2;
    chk("midrst_bclk", 32'(bclk_o), 0);
    chk("midrst_lrclk", 32'(lrclk_o), 0);
    chk("midrst_data", 32'(audio_data_o), 0);
    chk("midrst_new_sample", 32'(new_sample_o), 0);
    ns_seen = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (new_sample_o) ns_seen++;
    end
    chk("midrst_no_pulse", ns_seen, 0);
    chk("final_no_pending", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
